// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the 8-bit synchronous FIFO and sends each one as a
// UART frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic       tx_en,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(7);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   baud_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [7:0]         shreg;
    logic               par_acc;

    // Frame sequencer: state, baud timing, shift register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            fifo_rd    <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_rd    <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tx_en && !fifo_empty) begin
                        state   <= FETCH;
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    // FIFO data is valid the cycle after the read strobe.
                    shreg    <= fifo_dout;
                    par_acc  <= PARITY_ODD;
                    bit_idx  <= '0;
                    baud_cnt <= '0;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        par_acc  <= par_acc ^ shreg[0];
                        shreg    <= shreg >> 1;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_EN) begin
                                tx    <= par_acc ^ shreg[0];
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt   <= baud_cnt + CNT_W'(1);
                        // Registered one cycle early so it lands on the final stop cycle.
                        frame_done <= (baud_cnt == CNT_PRE_LAST);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four parameter sets run side by side, each with a FIFO
// model, random and directed traffic, and a frame-decoding scoreboard monitor.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic check(input string name, input int cfg, input logic [31:0] act,
                         input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, name, act, want);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int unsigned CPB  = (g == 3) ? 2 : 4;
        localparam bit          PE   = (g == 1 || g == 2);
        localparam bit          PO   = (g == 2);
        localparam int          FLEN = (10 + (PE ? 1 : 0)) * int'(CPB);

        logic       rst_n;
        logic [7:0] fifo_dout;
        logic       fifo_empty;
        logic       fifo_rd;
        logic       tx_en;
        logic       tx;
        logic       busy;
        logic       frame_done;

        logic [7:0] fifo_q[$];
        logic [7:0] exp_q[$];
        int         rd_log[$];
        int         cyc        = 0;
        int         last_rd    = -1;
        int         rd_cnt     = 0;
        int         frames     = 0;
        int         push_total = 0;
        bit         hold       = 1'b0;

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .fifo_dout (fifo_dout),
            .fifo_empty(fifo_empty),
            .fifo_rd   (fifo_rd),
            .tx_en     (tx_en),
            .tx        (tx),
            .busy      (busy),
            .frame_done(frame_done)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Expected line level for frame bit k of byte b.
        function automatic logic exp_bit(input logic [7:0] b, input int k);
            if (k == 0) return 1'b0;
            if (k <= 8) return b[k-1];
            if (PE && k == 9) return (^b) ^ PO;
            return 1'b1;
        endfunction

        // One clock of the FIFO model; pops on a read strobe and scrambles idle data.
        task automatic tick(input int n);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                if (fifo_rd === 1'b1) begin
                    check("rd_while_enabled", g, 32'(tx_en), 32'(1));
                    check("rd_nonempty", g, 32'(fifo_q.size() > 0), 32'(1));
                    if (last_rd >= 0)
                        check("rd_spacing", g, 32'((cyc - last_rd) >= FLEN + 3), 32'(1));
                    if (fifo_q.size() > 0) begin
                        fifo_dout = fifo_q.pop_front();
                        exp_q.push_back(fifo_dout);
                    end
                    hold    = 1'b1;
                    last_rd = cyc;
                    rd_cnt++;
                    rd_log.push_back(cyc);
                end else if (hold) begin
                    hold = 1'b0;
                end else begin
                    fifo_dout = 8'($urandom);
                end
                fifo_empty = (fifo_q.size() == 0);
            end
        endtask

        task automatic push(input logic [7:0] b);
            fifo_q.push_back(b);
            fifo_empty = 1'b0;
            push_total++;
        endtask

        task automatic drain(input int max_cyc);
            int k;
            k = 0;
            do begin
                tick(1);
                k++;
            end while ((fifo_q.size() != 0 || busy !== 1'b0 || exp_q.size() != 0) && k < max_cyc);
            check("drain_in_time", g, 32'(k < max_cyc), 32'(1));
        endtask

        // Stimulus: directed cases from the test plan, then random traffic.
        initial begin : stim
            logic [7:0] dir_bytes [3];
            logic [7:0] b2b_bytes [3];
            int base;
            int n0;
            dir_bytes = '{8'hA5, 8'h01, 8'h80};
            b2b_bytes = '{8'h00, 8'hFF, 8'h3C};
            tx_en      = 1'b0;
            fifo_empty = 1'b1;
            fifo_dout  = 8'h00;
            rst_n      = 1'b0;
            repeat (3) @(negedge clk);
            check("rst_tx", g, 32'(tx), 32'(1));
            check("rst_busy", g, 32'(busy), 32'(0));
            check("rst_rd", g, 32'(fifo_rd), 32'(0));
            check("rst_frame_done", g, 32'(frame_done), 32'(0));
            rst_n = 1'b1;

            tx_en = 1'b1;
            tick(100);
            check("empty_no_rd", g, 32'(rd_cnt), 32'(0));
            check("empty_tx_high", g, 32'(tx), 32'(1));

            for (int i = 0; i < 3; i++) begin
                base = cyc;
                n0   = rd_cnt;
                push(dir_bytes[i]);
                tick(1);
                check("rd_latency", g, 32'(last_rd - base), 32'(1));
                check("rd_single", g, 32'(rd_cnt - n0), 32'(1));
                drain(400);
            end

            n0 = rd_log.size();
            for (int i = 0; i < 3; i++) push(b2b_bytes[i]);
            drain(600);
            check("b2b_reads", g, 32'(rd_log.size() - n0), 32'(3));
            if (rd_log.size() >= n0 + 3) begin
                check("b2b_gap0", g, 32'(rd_log[n0+1] - rd_log[n0]), 32'(FLEN + 3));
                check("b2b_gap1", g, 32'(rd_log[n0+2] - rd_log[n0+1]), 32'(FLEN + 3));
            end
            tick(FLEN);
            check("b2b_no_fourth", g, 32'(rd_log.size() - n0), 32'(3));

            tx_en = 1'b0;
            n0 = rd_cnt;
            push(8'h5A);
            push(8'hC3);
            tick(60);
            check("disabled_no_rd", g, 32'(rd_cnt - n0), 32'(0));
            tx_en = 1'b1;
            tick(1);
            check("enable_rd", g, 32'(rd_cnt - n0), 32'(1));
            tick(3 * int'(CPB));
            tx_en = 1'b0;
            tick(FLEN + 20);
            check("drop_one_rd", g, 32'(rd_cnt - n0), 32'(1));
            check("drop_fifo_left", g, 32'(fifo_q.size()), 32'(1));
            check("drop_idle", g, 32'(busy), 32'(0));
            tx_en = 1'b1;
            drain(400);

            n0 = rd_cnt;
            push(8'($urandom));
            push(8'($urandom));
            tick(1);
            check("rst_case_rd", g, 32'(rd_cnt - n0), 32'(1));
            tick(4 * int'(CPB) + 2 + int'(CPB) / 2);
            check("pre_rst_busy", g, 32'(busy), 32'(1));
            #2 rst_n = 1'b0;
            #1;
            check("midrst_tx", g, 32'(tx), 32'(1));
            check("midrst_busy", g, 32'(busy), 32'(0));
            check("midrst_rd", g, 32'(fifo_rd), 32'(0));
            exp_q.delete();
            last_rd = -1;
            push_total--;
            tick(3);
            rst_n = 1'b1;
            base = cyc;
            tick(1);
            check("post_rst_rd_latency", g, 32'(last_rd - base), 32'(1));
            drain(400);
            check("post_rst_reads", g, 32'(rd_cnt - n0), 32'(2));

            for (int it = 0; it < 25; it++) begin
                repeat ($urandom_range(0, 2)) push(8'($urandom));
                tx_en = ($urandom_range(0, 3) != 0);
                tick($urandom_range(1, 60));
            end
            tx_en = 1'b1;
            drain(4000);
            check("fifo_drained", g, 32'(fifo_q.size()), 32'(0));
            check("frame_count", g, 32'(frames), 32'(push_total));
            done_cnt++;
        end

        // Monitor: decode each frame on the line and compare against the scoreboard queue.
        initial begin : mon
            logic [7:0] b;
            logic [7:0] dec;
            int  bad_tx;
            int  bad_busy;
            int  bad_fd;
            int  bidx;
            bit  aborted;
            forever begin
                @(negedge clk);
                if (rst_n === 1'b1 && tx === 1'b0) begin
                    check("rd_to_start", g, 32'(cyc - last_rd), 32'(2));
                    check("frame_expected", g, 32'(exp_q.size() > 0), 32'(1));
                    b        = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
                    dec      = 8'h00;
                    bad_tx   = 0;
                    bad_busy = 0;
                    bad_fd   = 0;
                    aborted  = 1'b0;
                    for (int t = 0; t < FLEN; t++) begin
                        if (t != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        bidx = t / int'(CPB);
                        if (tx !== exp_bit(b, bidx)) bad_tx++;
                        if (bidx >= 1 && bidx <= 8 && (t % int'(CPB)) == int'(CPB) / 2)
                            dec[bidx-1] = tx;
                        if (busy !== 1'b1) bad_busy++;
                        if (frame_done !== (t == FLEN - 1)) bad_fd++;
                    end
                    if (!aborted) begin
                        check("frame_byte", g, 32'(dec), 32'(b));
                        check("frame_bits", g, 32'(bad_tx), 32'(0));
                        check("frame_busy", g, 32'(bad_busy), 32'(0));
                        check("frame_done_pos", g, 32'(bad_fd), 32'(0));
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        frames++;
                        @(negedge clk);
                        if (rst_n === 1'b1) begin
                            check("post_frame_tx", g, 32'(tx), 32'(1));
                            check("post_frame_busy", g, 32'(busy), 32'(0));
                        end
                    end
                end
            end
        end
    end

    // Bounded wait for every configuration, then the summary.
    initial begin : wd
        int i;
        i = 0;
        while (done_cnt < 4 && i < 30000) begin
            @(posedge clk);
            i++;
        end
        checks++;
        if (done_cnt < 4) begin
            errors++;
            $display("FAIL watchdog: finished %0d of 4 configurations", done_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 8-bit synchronous FIFO. It pops one byte at a time through the FIFO read port and serialises it as an asynchronous UART frame: one start bit, eight data bits sent LSB first, an optional parity bit and one stop bit. It sits between the FIFO's read side and the chip's serial TX pin. It is the consumer for anything the write side pushes into the FIFO.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Legal range is 2..65535.
- PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, default 0: selects parity type when PARITY_EN=1. 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock; all logic is clocked on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fifo_dout  input  8  FIFO read data. Valid on the cycle after fifo_rd is high.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd  output  1  FIFO read strobe. Registered, one-cycle pulse per byte.
- tx_en  input  1  when 1, the block may fetch new bytes. When 0, a frame in progress still completes.
- tx  output  1  serial line. Idles high.
- busy  output  1  high whenever state ≠ IDLE.
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- States and transitions:
  - IDLE → FETCH when tx_en=1 and fifo_empty=0.
  - FETCH → LOAD.
  - LOAD → START.
  - START → DATA.
  - DATA → PARITY if PARITY_EN=1, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- FETCH:
  - fifo_rd=1 for exactly this one cycle.
  - FETCH is entered only from IDLE with fifo_empty=0 sampled, so fifo_rd is never asserted on an empty FIFO.
  - No second read occurs until the current frame ends.
- LOAD:
  - fifo_dout is captured into the 8-bit shift register.
  - The parity accumulator is cleared to PARITY_ODD.
- Bit timing:
  - The baud counter counts 0..CLKS_PER_BIT-1 inside START, DATA, PARITY and STOP.
  - The state (or bit index) advances when the counter reaches CLKS_PER_BIT-1.
  - The counter resets to 0 on every state entry.
- Bit values:
  - START: tx=0.
  - DATA: tx = shreg[0]. The register shifts right at each bit boundary. A 3-bit index counts 0..7, and DATA exits after index 7 completes.
  - Parity bit = PARITY_ODD XOR (XOR of all 8 data bits).
  - STOP: tx=1.
- tx is driven from a register, with no combinational glitch path.
- tx_en is sampled only in IDLE. Deasserting it mid-frame does not shorten or abort the frame.
- fifo_empty changes outside IDLE are ignored.
- fifo_dout is ignored in every state except LOAD.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - tx=1, fifo_rd=0, busy=0, frame_done=0.
  - state=IDLE, all counters 0, shreg 0.
- Reset mid-frame:
  - tx returns high immediately.
  - The in-flight byte is discarded and the FIFO is not re-read.
  - After release, the block restarts in IDLE.
- Latency from fifo_empty=0 (and tx_en=1) sampled at edge N:
  - fifo_rd is high in cycle N+1.
  - The byte is captured at the end of cycle N+2.
  - tx falls at the start of cycle N+3.
- Frame length: (10 + PARITY_EN) × CLKS_PER_BIT cycles, from the falling edge of the start bit to the end of the stop bit.
- frame_done is high in the final cycle of STOP.
- Back-to-back frames with the FIFO non-empty:
  - Exactly 3 extra tx-high cycles (IDLE, FETCH, LOAD) separate one stop bit from the next start bit.
  - Inter-frame fifo_rd pulses are therefore (10 + PARITY_EN) × CLKS_PER_BIT + 3 cycles apart.
- Simultaneous events:
  - If fifo_empty deasserts in the same cycle STOP→IDLE occurs, the FETCH is taken on the next edge.
  - If tx_en falls in that same cycle, no FETCH occurs.

## Test plan
1. Single byte: CLKS_PER_BIT=4, PARITY_EN=0, preload FIFO with 0xA5, tx_en=1.
   - Required: one fifo_rd pulse.
   - tx = 0,1,0,1,0,0,1,0,1,1, each bit held for 4 cycles.
   - frame_done once, then busy=0 and tx=1.
2. Parity: PARITY_EN=1 with 0xA5.
   - Even parity (PARITY_ODD=0): bit 9 = 0. Odd parity (PARITY_ODD=1): bit 9 = 1.
   - Frame = 44 cycles.
   - Repeat with 0x01: even-parity bit = 1.
3. Back-to-back: FIFO holds 0x00, 0xFF, 0x3C.
   - Required: three fifo_rd pulses 43 cycles apart (CLKS_PER_BIT=4, no parity).
   - A 3-cycle high gap between frames.
   - Bytes are decoded in order, and the FIFO ends empty with no fourth read.
4. Empty / enable gating:
   - FIFO empty: fifo_rd stays 0 and tx stays 1 for 100 cycles.
   - tx_en=0 with FIFO non-empty: no fifo_rd.
   - tx_en dropped mid-frame: the current frame completes and no further fetch occurs.
5. Reset mid-frame: assert rst_n=0 during data bit 3.
   - Required: tx=1, busy=0 and fifo_rd=0 immediately.
   - After release with FIFO non-empty, the next byte is fetched with the N+1 rd / N+3 start latency.
6. Boundary CLKS_PER_BIT=2: 0x80 yields a 20-cycle frame, with tx high only in data bit 7 and the stop bit.
